// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets, CON bit
// positions, the state encoding used by both serial FSMs and the oversample rate.
package uart_pkg;

    localparam logic [31:0] OFF_TXD = 32'h0000_0000;
    localparam logic [31:0] OFF_RXD = 32'h0000_0004;
    localparam logic [31:0] OFF_CON = 32'h0000_0008;

    localparam int CON_TX_BUSY    = 0;
    localparam int CON_RX_VALID   = 1;
    localparam int CON_RX_OVERRUN = 2;
    localparam int CON_TX_DROP    = 3;
    localparam int CON_FRAME_ERR  = 4;
    localparam int CON_IRQ_EN     = 5;

    localparam int OVERSAMPLE = 16;

    // Last tick of a bit period, and the tick that lands mid-way through a bit
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample divider: counts 0..DIV-1 and asserts tick for the
// single clock in which the count sits at DIV-1.
module uart_baud_tick #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/uart_bus_slave.sv
// Memory-mapped 8N1 UART on the CPU data bus (TXD / RXD / CON word registers).
// Optional interrupt output and CON.irq_en are built when UART_IRQ_EN is defined.
module uart_bus_slave
    import uart_pkg::*;
#(
    parameter int          CLK_FREQ  = 100_000_000,
    parameter int          BAUD      = 9600,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        Mem_rd,
    input  logic        Mem_wr,
    input  logic [31:0] Write_data,
    output logic [31:0] Read_data,
    input  logic        uart_rxd,
    output logic        uart_txd
`ifdef UART_IRQ_EN
    ,
    output logic        uart_irq
`endif
);

    localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

    localparam logic [31:0] TXD_ADDR = BASE_ADDR + OFF_TXD;
    localparam logic [31:0] RXD_ADDR = BASE_ADDR + OFF_RXD;
    localparam logic [31:0] CON_ADDR = BASE_ADDR + OFF_CON;

    logic        w_tick;
    logic        w_hitTxd, w_hitRxd, w_hitCon;
    logic        w_wrTxd, w_wrCon, w_rdRxd;
    logic [2:0]  w_clr;
    logic [31:0] w_conValue;
    logic        w_irqEnBit;
    logic        w_unused;

    uart_state_t r_txState, w_txStateNext;
    logic [3:0]  r_txTickCnt, w_txTickCntNext;
    logic [2:0]  r_txBitIdx, w_txBitIdxNext;
    logic [7:0]  r_txShift, w_txShiftNext;
    logic        r_txd, w_txdNext;
    logic        r_txBusy, w_txBusyNext;

    logic        r_rxSync1, r_rxSync2, r_rxPrev;
    logic        w_rxFall;
    uart_state_t r_rxState, w_rxStateNext;
    logic [3:0]  r_rxTickCnt, w_rxTickCntNext;
    logic [2:0]  r_rxBitIdx, w_rxBitIdxNext;
    logic [7:0]  r_rxShift, w_rxShiftNext;
    logic        w_rxDone, w_rxFrameErr;
    logic [7:0]  r_rxByte;
    logic        r_rxValid;

    logic        r_rxOverrun, r_txDrop, r_frameErr;

    uart_baud_tick #(.DIV(DIV)) u_baud (
        .clk   (clk),
        .reset (reset),
        .tick  (w_tick)
    );

    // Word decode: the byte offset within a register is irrelevant
    assign w_hitTxd = (addr[31:2] == TXD_ADDR[31:2]);
    assign w_hitRxd = (addr[31:2] == RXD_ADDR[31:2]);
    assign w_hitCon = (addr[31:2] == CON_ADDR[31:2]);

    assign w_wrTxd = Mem_wr & w_hitTxd;
    assign w_wrCon = Mem_wr & w_hitCon;
    assign w_rdRxd = Mem_rd & w_hitRxd;
    assign w_clr   = {Write_data[CON_FRAME_ERR], Write_data[CON_TX_DROP],
                      Write_data[CON_RX_OVERRUN]} & {3{w_wrCon}};

    assign w_unused = ^{addr[1:0], Write_data[31:8]};

    always_comb begin
        w_conValue                 = '0;
        w_conValue[CON_TX_BUSY]    = r_txBusy;
        w_conValue[CON_RX_VALID]   = r_rxValid;
        w_conValue[CON_RX_OVERRUN] = r_rxOverrun;
        w_conValue[CON_TX_DROP]    = r_txDrop;
        w_conValue[CON_FRAME_ERR]  = r_frameErr;
        w_conValue[CON_IRQ_EN]     = w_irqEnBit;
    end

    // Reads see pre-edge register values, so a simultaneous store never leaks in
    always_comb begin
        Read_data = '0;
        if (Mem_rd) begin
            if (w_hitRxd) begin
                Read_data = {24'b0, r_rxByte};
            end else if (w_hitCon) begin
                Read_data = w_conValue;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_txState   <= ST_IDLE;
            r_txTickCnt <= '0;
            r_txBitIdx  <= '0;
            r_txShift   <= '0;
            r_txd       <= 1'b1;
            r_txBusy    <= 1'b0;
        end else begin
            r_txState   <= w_txStateNext;
            r_txTickCnt <= w_txTickCntNext;
            r_txBitIdx  <= w_txBitIdxNext;
            r_txShift   <= w_txShiftNext;
            r_txd       <= w_txdNext;
            r_txBusy    <= w_txBusyNext;
        end
    end

    // The line is registered, so each next-state branch also chooses the next bit level
    always_comb begin
        w_txStateNext   = r_txState;
        w_txTickCntNext = r_txTickCnt;
        w_txBitIdxNext  = r_txBitIdx;
        w_txShiftNext   = r_txShift;
        w_txdNext       = r_txd;
        w_txBusyNext    = r_txBusy;
        case (r_txState)
            ST_IDLE: begin
                w_txdNext = 1'b1;
                if (w_wrTxd && !r_txBusy) begin
                    w_txStateNext   = ST_START;
                    w_txTickCntNext = '0;
                    w_txShiftNext   = Write_data[7:0];
                    w_txdNext       = 1'b0;
                    w_txBusyNext    = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_txTickCnt == TICK_LAST) begin
                        w_txStateNext   = ST_DATA;
                        w_txTickCntNext = '0;
                        w_txBitIdxNext  = '0;
                        w_txdNext       = r_txShift[0];
                    end else begin
                        w_txTickCntNext = r_txTickCnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_txTickCnt == TICK_LAST) begin
                        w_txTickCntNext = '0;
                        if (r_txBitIdx == 3'd7) begin
                            w_txStateNext = ST_STOP;
                            w_txdNext     = 1'b1;
                        end else begin
                            w_txBitIdxNext = r_txBitIdx + 3'd1;
                            w_txShiftNext  = {1'b0, r_txShift[7:1]};
                            w_txdNext      = r_txShift[1];
                        end
                    end else begin
                        w_txTickCntNext = r_txTickCnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_txTickCnt == TICK_LAST) begin
                        w_txStateNext   = ST_IDLE;
                        w_txTickCntNext = '0;
                        w_txdNext       = 1'b1;
                        w_txBusyNext    = 1'b0;
                    end else begin
                        w_txTickCntNext = r_txTickCnt + 4'd1;
                    end
                end
            end
            default: begin
                w_txStateNext = ST_IDLE;
            end
        endcase
    end

    assign uart_txd = r_txd;

    // Synchronizer flops reset high so a released reset never looks like a start edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxSync1 <= 1'b1;
            r_rxSync2 <= 1'b1;
            r_rxPrev  <= 1'b1;
        end else begin
            r_rxSync1 <= uart_rxd;
            r_rxSync2 <= r_rxSync1;
            r_rxPrev  <= r_rxSync2;
        end
    end

    assign w_rxFall = r_rxPrev & ~r_rxSync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxState   <= ST_IDLE;
            r_rxTickCnt <= '0;
            r_rxBitIdx  <= '0;
            r_rxShift   <= '0;
        end else begin
            r_rxState   <= w_rxStateNext;
            r_rxTickCnt <= w_rxTickCntNext;
            r_rxBitIdx  <= w_rxBitIdxNext;
            r_rxShift   <= w_rxShiftNext;
        end
    end

    always_comb begin
        w_rxStateNext   = r_rxState;
        w_rxTickCntNext = r_rxTickCnt;
        w_rxBitIdxNext  = r_rxBitIdx;
        w_rxShiftNext   = r_rxShift;
        w_rxDone        = 1'b0;
        w_rxFrameErr    = 1'b0;
        case (r_rxState)
            ST_IDLE: begin
                if (w_rxFall) begin
                    w_rxStateNext   = ST_START;
                    w_rxTickCntNext = '0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    if (r_rxTickCnt == TICK_MID) begin
                        w_rxTickCntNext = '0;
                        w_rxBitIdxNext  = '0;
                        w_rxStateNext   = r_rxSync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        w_rxTickCntNext = r_rxTickCnt + 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_rxTickCnt == TICK_LAST) begin
                        w_rxTickCntNext = '0;
                        w_rxShiftNext   = {r_rxSync2, r_rxShift[7:1]};
                        if (r_rxBitIdx == 3'd7) begin
                            w_rxStateNext = ST_STOP;
                        end else begin
                            w_rxBitIdxNext = r_rxBitIdx + 3'd1;
                        end
                    end else begin
                        w_rxTickCntNext = r_rxTickCnt + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_rxTickCnt == TICK_LAST) begin
                        w_rxStateNext   = ST_IDLE;
                        w_rxTickCntNext = '0;
                        w_rxDone        = r_rxSync2;
                        w_rxFrameErr    = ~r_rxSync2;
                    end else begin
                        w_rxTickCntNext = r_rxTickCnt + 4'd1;
                    end
                end
            end
            default: begin
                w_rxStateNext = ST_IDLE;
            end
        endcase
    end

    // A completing byte outranks a concurrent RXD load, keeping rx_valid set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxByte  <= '0;
            r_rxValid <= 1'b0;
        end else begin
            if (w_rxDone) begin
                r_rxByte  <= r_rxShift;
                r_rxValid <= 1'b1;
            end else if (w_rdRxd) begin
                r_rxValid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rxOverrun <= 1'b0;
            r_txDrop    <= 1'b0;
            r_frameErr  <= 1'b0;
        end else begin
            r_rxOverrun <= (r_rxOverrun & ~w_clr[0]) | (w_rxDone & r_rxValid);
            r_txDrop    <= (r_txDrop & ~w_clr[1]) | (w_wrTxd & r_txBusy);
            r_frameErr  <= (r_frameErr & ~w_clr[2]) | w_rxFrameErr;
        end
    end

`ifdef UART_IRQ_EN
    logic r_irqEn;
    logic r_irq;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_irqEn <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wrCon) begin
                r_irqEn <= Write_data[CON_IRQ_EN];
            end
            r_irq <= r_irqEn & (r_rxValid | ~r_txBusy);
        end
    end

    assign w_irqEnBit = r_irqEn;
    assign uart_irq   = r_irq;
`else
    assign w_irqEnBit = 1'b0;
`endif

endmodule

// File: tb/tb_uart_bus_slave.sv
// Directed self-checking bench for uart_bus_slave at DIV=10 (160 clocks per bit).
// The interrupt steps are compiled only when UART_IRQ_EN is defined.
module tb_uart_bus_slave;

    localparam logic [31:0] A_TXD = 32'h4000_0018;
    localparam logic [31:0] A_RXD = 32'h4000_001C;
    localparam logic [31:0] A_CON = 32'h4000_0020;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = '0;
    logic        Mem_rd = 1'b0;
    logic        Mem_wr = 1'b0;
    logic [31:0] Write_data = '0;
    logic [31:0] Read_data;
    logic        uart_rxd = 1'b1;
    logic        uart_txd;
`ifdef UART_IRQ_EN
    logic        uart_irq;
`endif

    int          checkCount = 0;
    int          errorCount = 0;
    int          cycleCnt = 0;
    int          s;
    logic [31:0] rd;

    uart_bus_slave #(
        .CLK_FREQ  (1_600_000),
        .BAUD      (10_000),
        .BASE_ADDR (32'h4000_0018)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .addr       (addr),
        .Mem_rd     (Mem_rd),
        .Mem_wr     (Mem_wr),
        .Write_data (Write_data),
        .Read_data  (Read_data),
        .uart_rxd   (uart_rxd),
        .uart_txd   (uart_txd)
`ifdef UART_IRQ_EN
        ,
        .uart_irq   (uart_irq)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One bus cycle: drive on the falling edge, capture the combinational read before the rising edge
    task automatic applyStimulus(input logic rdEn, input logic wrEn, input logic [31:0] a,
                                 input logic [31:0] d, output logic [31:0] rdata);
        @(negedge clk);
        addr = a;
        Mem_rd = rdEn;
        Mem_wr = wrEn;
        Write_data = d;
        #1 rdata = Read_data;
        @(posedge clk);
        #1;
        Mem_rd = 1'b0;
        Mem_wr = 1'b0;
        addr = '0;
        Write_data = '0;
    endtask

    task automatic waitCycle(input int target);
        while (cycleCnt < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Mid-bit samples relative to the accepting edge tolerate the unknown tick phase
    task automatic checkTxFrame(input logic [7:0] b, input int storeCycle, input string tag);
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        for (int j = 0; j < 10; j++) begin
            waitCycle(storeCycle + 80 + 160 * j);
            checkOutput($sformatf("%s_bit%0d", tag, j), {31'b0, uart_txd}, {31'b0, frame[j]});
        end
    endtask

    task automatic driveRxFrame(input logic [7:0] b, input logic stopBit);
        logic [9:0] frame;
        frame = {stopBit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            uart_rxd = frame[i];
            repeat (159) @(negedge clk);
        end
        @(negedge clk);
        uart_rxd = 1'b1;
    endtask

    initial begin
        #(900_000);
        $display("[TB] FAIL watchdog cycles=%0d", cycleCnt);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Power-on reset
        repeat (3) @(posedge clk);
        #1 checkOutput("rst_txd", {31'b0, uart_txd}, 32'h1);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("rst_con", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, A_RXD, 32'h0, rd);
        checkOutput("rst_rxd", rd, 32'h0);

        // Reset in the middle of a start bit
        applyStimulus(1'b0, 1'b1, A_TXD, 32'h55, rd);
        s = cycleCnt;
        waitCycle(s + 40);
        checkOutput("pre_rst_txd", {31'b0, uart_txd}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 checkOutput("midrst_txd", {31'b0, uart_txd}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("midrst_con", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, A_RXD, 32'h0, rd);
        checkOutput("midrst_rxd", rd, 32'h0);
        s = cycleCnt;
        waitCycle(s + 200);
        checkOutput("midrst_idle", {31'b0, uart_txd}, 32'h1);

        // Single transmission of 0xA5 plus decode corner cases while busy
        applyStimulus(1'b0, 1'b1, A_TXD, 32'hA5, rd);
        s = cycleCnt;
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("tx_busy", rd, 32'h1);
        applyStimulus(1'b0, 1'b0, A_CON, 32'h0, rd);
        checkOutput("rd_gate", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, A_CON + 32'h2, 32'h0, rd);
        checkOutput("addr_lsb", rd, 32'h1);
        applyStimulus(1'b1, 1'b0, 32'h4000_0024, 32'h0, rd);
        checkOutput("unmapped", rd, 32'h0);
        applyStimulus(1'b1, 1'b0, A_TXD, 32'h0, rd);
        checkOutput("txd_load", rd, 32'h0);
        checkTxFrame(8'hA5, s, "tx1");
        waitCycle(s + 1600);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("tx_done_con", rd, 32'h0);

        // A store while busy is discarded and flagged
        applyStimulus(1'b0, 1'b1, A_TXD, 32'hA5, rd);
        s = cycleCnt;
        applyStimulus(1'b0, 1'b1, A_TXD, 32'h3C, rd);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("drop_con", rd, 32'h9);
        checkTxFrame(8'hA5, s, "tx2");
        waitCycle(s + 1700);
        checkOutput("drop_idle", {31'b0, uart_txd}, 32'h1);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("drop_sticky", rd, 32'h8);
        applyStimulus(1'b0, 1'b1, A_CON, 32'h8, rd);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("drop_clr", rd, 32'h0);

        // Receive path
        driveRxFrame(8'h5A, 1'b1);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("rx_con", rd, 32'h2);
        applyStimulus(1'b1, 1'b0, A_RXD, 32'h0, rd);
        checkOutput("rx_data", rd, 32'h5A);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("rx_clr", rd, 32'h0);

        driveRxFrame(8'h11, 1'b1);
        driveRxFrame(8'h22, 1'b1);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("ovr_con", rd, 32'h6);
        applyStimulus(1'b1, 1'b0, A_RXD, 32'h0, rd);
        checkOutput("ovr_data", rd, 32'h22);
        applyStimulus(1'b0, 1'b1, A_CON, 32'h4, rd);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("ovr_clr", rd, 32'h0);

        // Framing error, then a short glitch that must not start a frame
        driveRxFrame(8'h96, 1'b0);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("ferr_con", rd, 32'h10);
        applyStimulus(1'b0, 1'b1, A_CON, 32'h10, rd);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("ferr_clr", rd, 32'h0);
        @(negedge clk);
        uart_rxd = 1'b0;
        repeat (60) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (300) @(posedge clk);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("glitch_con", rd, 32'h0);
        driveRxFrame(8'hC3, 1'b1);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("post_glitch_con", rd, 32'h2);
        applyStimulus(1'b1, 1'b0, A_RXD, 32'h0, rd);
        checkOutput("post_glitch_rxd", rd, 32'hC3);

`ifdef UART_IRQ_EN
        applyStimulus(1'b0, 1'b1, A_CON, 32'h20, rd);
        checkOutput("irq_lat0", {31'b0, uart_irq}, 32'h0);
        @(posedge clk);
        #1 checkOutput("irq_on", {31'b0, uart_irq}, 32'h1);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("irq_en_bit", rd, 32'h20);
        applyStimulus(1'b0, 1'b1, A_TXD, 32'h81, rd);
        s = cycleCnt;
        @(posedge clk);
        #1 checkOutput("irq_busy", {31'b0, uart_irq}, 32'h0);
        waitCycle(s + 1700);
        checkOutput("irq_idle", {31'b0, uart_irq}, 32'h1);
`else
        applyStimulus(1'b0, 1'b1, A_CON, 32'h20, rd);
        applyStimulus(1'b1, 1'b0, A_CON, 32'h0, rd);
        checkOutput("irq_en_absent", rd, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
